// File: rtl/matmul_result_reader.sv
// Streams the matmul result matrix out of the engine's result memory as a valid/ready
// stream, tagging row ends and the final element; a 2-entry FWFT FIFO covers read latency.
module matmul_result_reader #(
    parameter int MATRIX_DIM = 32,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [ACC_WIDTH-1:0]  mem_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ACC_WIDTH-1:0]  m_data,
    output logic                  m_row_last,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state_dbg
);

    // Handshake: a beat transfers on a rising clk edge where m_valid & m_ready; once
    // m_valid is high, m_data/m_row_last/m_last hold until that transfer.

    localparam int CW = (MATRIX_DIM > 1) ? $clog2(MATRIX_DIM) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(MATRIX_DIM - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                state;
    logic [CW-1:0]         rd_i;
    logic [CW-1:0]         rd_j;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_pending;

    logic                  inflight;
    logic                  inflight_row_last;
    logic                  inflight_last;

    logic [ACC_WIDTH-1:0]  fifo_data     [2];
    logic                  fifo_row_last [2];
    logic                  fifo_last     [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_count;

    logic                  pop;
    logic                  push;
    logic [2:0]            occupancy;
    logic                  rd_row_last;
    logic                  rd_last;

    assign m_valid     = (fifo_count != 2'd0);
    assign m_data      = fifo_data[rd_ptr];
    assign m_row_last  = fifo_row_last[rd_ptr];
    assign m_last      = fifo_last[rd_ptr];
    assign pop         = m_valid & m_ready;
    assign push        = inflight;
    assign mem_rd_addr = rd_addr;
    assign state_dbg   = state;

    // Credit counts words already in the FIFO plus the one still in the memory pipe;
    // a pop this cycle frees a slot, so backpressure never overflows the 2 entries.
    assign occupancy   = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign mem_rd_en   = (state == S_STREAM) && rd_pending && (occupancy < 3'd2);

    assign rd_row_last = (rd_j == LAST_IDX);
    assign rd_last     = rd_row_last && (rd_i == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rd_i       <= '0;
            rd_j       <= '0;
            rd_addr    <= '0;
            rd_pending <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= S_STREAM;
                        busy       <= 1'b1;
                        rd_i       <= '0;
                        rd_j       <= '0;
                        rd_addr    <= '0;
                        rd_pending <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (mem_rd_en) begin
                        // The final address leaves the counters parked rather than wrapping.
                        if (rd_last) begin
                            rd_pending <= 1'b0;
                        end else begin
                            rd_addr <= rd_addr + ADDR_WIDTH'(1);
                            if (rd_row_last) begin
                                rd_j <= '0;
                                rd_i <= rd_i + CW'(1);
                            end else begin
                                rd_j <= rd_j + CW'(1);
                            end
                        end
                    end
                    if (pop && m_last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight          <= 1'b0;
            inflight_row_last <= 1'b0;
            inflight_last     <= 1'b0;
            wr_ptr            <= 1'b0;
            rd_ptr            <= 1'b0;
            fifo_count        <= 2'd0;
            for (int k = 0; k < 2; k++) begin
                fifo_data[k]     <= '0;
                fifo_row_last[k] <= 1'b0;
                fifo_last[k]     <= 1'b0;
            end
        end else begin
            inflight          <= mem_rd_en;
            inflight_row_last <= mem_rd_en & rd_row_last;
            inflight_last     <= mem_rd_en & rd_last;
            if (push) begin
                fifo_data[wr_ptr]     <= mem_rd_data;
                fifo_row_last[wr_ptr] <= inflight_row_last;
                fifo_last[wr_ptr]     <= inflight_last;
                wr_ptr                <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_matmul_result_reader.sv
// Directed bench for matmul_result_reader: a 4x4 instance with a behavioural result
// memory (C[k]=k+100) and a 1x1 instance holding 0xFFFFFFFF.
module tb_matmul_result_reader;

    localparam int DIM = 4;
    localparam int AW  = 32;
    localparam int ADW = 10;
    localparam int NB  = DIM * DIM;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start1 = 1'b0;
    logic m_ready = 1'b1;

    logic           mem_rd_en, m_valid, m_row_last, m_last, busy, done;
    logic [ADW-1:0] mem_rd_addr;
    logic [AW-1:0]  mem_rd_data = '0;
    logic [AW-1:0]  m_data;
    logic [1:0]     state_dbg;

    logic           mem_rd_en1, m_valid1, m_row_last1, m_last1, busy1, done1;
    logic [ADW-1:0] mem_rd_addr1;
    logic [AW-1:0]  mem_rd_data1 = '0;
    logic [AW-1:0]  m_data1;
    logic [1:0]     state_dbg1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    matmul_result_reader #(.MATRIX_DIM(DIM), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_row_last(m_row_last), .m_last(m_last),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    matmul_result_reader #(.MATRIX_DIM(1), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .mem_rd_en(mem_rd_en1), .mem_rd_addr(mem_rd_addr1), .mem_rd_data(mem_rd_data1),
        .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
        .m_row_last(m_row_last1), .m_last(m_last1),
        .busy(busy1), .done(done1), .state_dbg(state_dbg1)
    );

    // Synchronous-read result memories
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 32'd100 + 32'(mem_rd_addr);
        if (mem_rd_en1) mem_rd_data1 <= 32'hFFFF_FFFF;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consumer: 0 always ready, 1 toggle, 2 random 30%, 3 held low
    int ready_mode = 0;
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = ~m_ready;
            2: m_ready = ($urandom_range(0, 99) < 30);
            default: m_ready = 1'b0;
        endcase
    end

    // Scoreboard / protocol monitor on the 4x4 instance
    logic [AW-1:0]  exp_q[$];
    logic [ADW-1:0] rd_log[$];
    int beat_idx = 0, issued = 0, accepted = 0, done_cnt = 0;
    logic mon_en = 1'b0, exp_done = 1'b0, prev_stall = 1'b0, mon_pop;
    logic [AW+1:0] prev_beat;

    always @(negedge clk) begin
        if (mon_en) begin
            mon_pop = m_valid && m_ready;
            if (done || exp_done) chk("done_pulse", 64'(done), 64'(exp_done));
            if (done) done_cnt++;
            if (prev_stall) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_beat", 64'({m_data, m_row_last, m_last}), 64'(prev_beat));
            end
            if (mem_rd_en) begin
                chk("credit", 64'((issued - accepted - int'(mon_pop)) < 2), 64'd1);
                rd_log.push_back(mem_rd_addr);
                issued++;
            end
            if (mon_pop) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got %0h expected no beat", m_data);
                end else begin
                    chk("beat_data", 64'(m_data), 64'(exp_q.pop_front()));
                end
                chk("beat_row_last", 64'(m_row_last), 64'((beat_idx % DIM) == DIM - 1));
                chk("beat_last", 64'(m_last), 64'(beat_idx == NB - 1));
                accepted++;
                beat_idx = (beat_idx == NB - 1) ? 0 : beat_idx + 1;
            end
            exp_done   = mon_pop && m_last;
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_data, m_row_last, m_last};
        end
    end

    task automatic clear_mon();
        exp_q.delete();
        rd_log.delete();
        issued = 0; accepted = 0; done_cnt = 0; beat_idx = 0;
        exp_done = 1'b0; prev_stall = 1'b0;
    endtask

    task automatic load(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(32'd100 + 32'(k % NB));
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    // sel 0 waits on done pulses, sel 1 on accepted beats
    task automatic wait_cnt(input int sel, input int target, input int budget, input string name);
        int n = 0;
        while (((sel == 0) ? done_cnt : accepted) < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk(name, 64'(((sel == 0) ? done_cnt : accepted) >= target), 64'd1);
    endtask

    task automatic finish_drain(input string name);
        chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_beats"}, 64'(accepted), 64'(NB));
        chk({name, "_reads"}, 64'(issued), 64'(NB));
    endtask

    typedef struct {
        int            cyc;
        logic          rd_en;
        logic [ADW-1:0] addr;
        logic          valid;
        logic [AW-1:0] data;
        logic          rl;
        logic          last;
        logic          busy;
        logic          done;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1,  1'b1, 10'd0,  1'b0, 32'd0,   1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{2,  1'b1, 10'd1,  1'b0, 32'd0,   1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{3,  1'b1, 10'd2,  1'b1, 32'd100, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{4,  1'b1, 10'd3,  1'b1, 32'd101, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{6,  1'b1, 10'd5,  1'b1, 32'd103, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16, 1'b1, 10'd15, 1'b1, 32'd113, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{17, 1'b0, 10'd0,  1'b1, 32'd114, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{18, 1'b0, 10'd0,  1'b1, 32'd115, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{19, 1'b0, 10'd0,  1'b0, 32'd0,   1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{20, 1'b0, 10'd0,  1'b0, 32'd0,   1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_rd_addr", 64'(mem_rd_addr), 64'd0);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        chk("rst_tags", 64'({m_row_last, m_last}), 64'd0);
        chk("rst_busy_done", 64'({busy, done}), 64'd0);
        chk("rst_state", 64'(state_dbg), 64'd0);
        chk("rst1_valid_done", 64'({m_valid1, done1, busy1}), 64'd0);
        @(posedge clk); #2 rst = 1'b0;
        mon_en = 1'b1;

        // 1: full-rate drain, cycle-exact table
        clear_mon();
        load(NB);
        pulse_start();
        begin
            int vi = 0;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                if (vi < 10 && vecs[vi].cyc == c) begin
                    chk($sformatf("t1_c%0d_rd_en", c), 64'(mem_rd_en), 64'(vecs[vi].rd_en));
                    if (vecs[vi].rd_en)
                        chk($sformatf("t1_c%0d_addr", c), 64'(mem_rd_addr), 64'(vecs[vi].addr));
                    chk($sformatf("t1_c%0d_valid", c), 64'(m_valid), 64'(vecs[vi].valid));
                    if (vecs[vi].valid) begin
                        chk($sformatf("t1_c%0d_data", c), 64'(m_data), 64'(vecs[vi].data));
                        chk($sformatf("t1_c%0d_tags", c), 64'({m_row_last, m_last}),
                            64'({vecs[vi].rl, vecs[vi].last}));
                    end
                    chk($sformatf("t1_c%0d_busy", c), 64'(busy), 64'(vecs[vi].busy));
                    chk($sformatf("t1_c%0d_done", c), 64'(done), 64'(vecs[vi].done));
                    vi++;
                end
            end
        end
        #1;
        finish_drain("t1");

        // 2: toggling and random backpressure
        for (int mode = 1; mode <= 2; mode++) begin
            clear_mon();
            load(NB);
            ready_mode = mode;
            pulse_start();
            wait_cnt(0, 1, 1000, $sformatf("t2_m%0d_done_timeout", mode));
            finish_drain($sformatf("t2_m%0d", mode));
            ready_mode = 0;
            repeat (3) @(negedge clk);
        end

        // 3: consumer stalled from start
        clear_mon();
        load(NB);
        ready_mode = 3;
        pulse_start();
        repeat (20) @(negedge clk);
        #1;
        chk("t3_reads_issued", 64'(issued), 64'd2);
        if (rd_log.size() >= 2) begin
            chk("t3_addr0", 64'(rd_log[0]), 64'd0);
            chk("t3_addr1", 64'(rd_log[1]), 64'd1);
        end
        chk("t3_valid_held", 64'(m_valid), 64'd1);
        chk("t3_data_held", 64'(m_data), 64'd100);
        chk("t3_rd_en_idle", 64'(mem_rd_en), 64'd0);
        ready_mode = 0;
        wait_cnt(0, 1, 200, "t3_done_timeout");
        finish_drain("t3");
        repeat (3) @(negedge clk);

        // 4: start held high -> two back-to-back drains
        clear_mon();
        load(2 * NB);
        @(posedge clk); #2 start = 1'b1;
        wait_cnt(0, 2, 200, "t4_done_timeout");
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("t4_done_count", 64'(done_cnt), 64'd2);
        chk("t4_beats", 64'(accepted), 64'(2 * NB));
        chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t4_idle_busy", 64'(busy), 64'd0);

        // 5: asynchronous reset mid-drain
        clear_mon();
        load(NB);
        pulse_start();
        wait_cnt(1, 6, 100, "t5_beats_timeout");
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_async_valid", 64'(m_valid), 64'd0);
        chk("t5_async_rd_en", 64'(mem_rd_en), 64'd0);
        chk("t5_async_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        clear_mon();
        mon_en = 1'b1;
        load(NB);
        pulse_start();
        wait_cnt(0, 1, 200, "t5_done_timeout");
        finish_drain("t5");
        chk("t5_first_addr", 64'(rd_log.size() > 0 ? rd_log[0] : 10'h3FF), 64'd0);

        // 6: 1x1 matrix
        @(posedge clk); #2 start1 = 1'b1;
        @(posedge clk); #2 start1 = 1'b0;
        @(negedge clk);
        chk("t6_c1_rd", 64'({mem_rd_en1, mem_rd_addr1}), 64'({1'b1, 10'd0}));
        @(negedge clk);
        chk("t6_c2_rd_en", 64'(mem_rd_en1), 64'd0);
        chk("t6_c2_valid", 64'(m_valid1), 64'd0);
        @(negedge clk);
        chk("t6_c3_valid", 64'(m_valid1), 64'd1);
        chk("t6_c3_data", 64'(m_data1), 64'hFFFF_FFFF);
        chk("t6_c3_tags", 64'({m_row_last1, m_last1}), 64'd3);
        @(negedge clk);
        chk("t6_c4_done", 64'(done1), 64'd1);
        chk("t6_c4_valid", 64'(m_valid1), 64'd0);
        @(negedge clk);
        chk("t6_c5_done", 64'(done1), 64'd0);
        chk("t6_c5_busy", 64'(busy1), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
